wb_load_queue: RTL

- Parametrised successor to the writeback load-alignment logic.
- In-order queue of outstanding loads sitting between the memory stage and the register-file write port.
- Per load: records size, sign and byte offset at issue; captures the data-channel response; shifts and zero/sign-extends it; presents a registered writeback (data + rd) with valid/ready.
- Supports 32/64-bit data, configurable depth, and pipeline flush with in-flight response discard.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/load_align.sv | 41 ++++
 rtl/wb_load_queue_chk.sv | 15 +
 rtl/wb_load_queue.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared load-path definitions: access size codes, load-queue entry states and
// the per-load metadata record captured when a load is issued.
package cpu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // Metadata fields are sized for the widest supported bus and register index.
  localparam int OFF_MAX_W = 3;
  localparam int RD_MAX_W  = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2
  } ent_state_e;

  typedef struct packed {
    logic [1:0]           size;
    logic                 sgn;
    logic [OFF_MAX_W-1:0] off;
    logic [RD_MAX_W-1:0]  rd;
  } ld_meta_t;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: shift the bus word down by the byte offset and
// zero/sign-extend the selected byte, half, word or dword to the bus width.
module load_align
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]           data_i,
  input  logic [1:0]                  size_i,
  input  logic                        sign_i,
  input  logic [$clog2(DATA_W/8)-1:0] off_i,
  output logic [DATA_W-1:0]           data_o
);

  logic [DATA_W-1:0] shifted_s;
  logic [DATA_W-1:0] mask_s;
  logic [DATA_W-1:0] msb_s;
  logic [6:0]        raw_w_s;
  logic [6:0]        width_s;
  logic              neg_s;

  assign shifted_s = data_i >> {off_i, 3'b000};

  // Access width in bits before clamping to the bus
  always_comb begin
    case (size_i)
      SZ_B:    raw_w_s = 7'd8;
      SZ_H:    raw_w_s = 7'd16;
      SZ_W:    raw_w_s = 7'd32;
      default: raw_w_s = 7'd64;
    endcase
  end

  // A full-width access yields an all-ones mask, so it is never extended.
  assign width_s = (raw_w_s > 7'(DATA_W)) ? 7'(DATA_W) : raw_w_s;
  assign mask_s  = ~({DATA_W{1'b1}} << width_s);
  assign msb_s   = mask_s & ~(mask_s >> 1);
  assign neg_s   = sign_i && (|(shifted_s & msb_s));
  assign data_o  = (shifted_s & mask_s) | (neg_s ? ~mask_s : {DATA_W{1'b0}});

endmodule

// File: rtl/wb_load_queue_chk.sv
// Protocol checker for wb_load_queue: flags data responses that arrive with no
// outstanding load and nothing left to drop.
module wb_load_queue_chk (
  input logic clk,
  input logic rst,
  input logic rsp_valid,
  input logic drop_zero,
  input logic wait_none
);

  a_rsp_orphan: assert property (@(posedge clk) disable iff (rst)
    !(rsp_valid && drop_zero && wait_none))
    else $error("wb_load_queue: response with no outstanding load");

endmodule

// File: rtl/wb_load_queue.sv
// In-order load queue between memory stage and register-file write port.
// Optional same-cycle response bypass to the writeback port: WB_LOAD_BYPASS_EN.
module wb_load_queue
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int RD_W   = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [1:0]                  req_size,
  input  logic                        req_signed,
  input  logic [$clog2(DATA_W/8)-1:0] req_off,
  input  logic [RD_W-1:0]             req_rd,
  input  logic                        rsp_valid,
  input  logic [DATA_W-1:0]           rsp_data,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [DATA_W-1:0]           wb_data,
  output logic [RD_W-1:0]             wb_rd,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DATA_W/8);

  typedef logic [PW:0]   ptr_t;
  typedef logic [PW-1:0] idx_t;
  typedef logic [PW+1:0] occ_t;

  ent_state_e        st_q [DEPTH];
  ent_state_e        st_d [DEPTH];
  ld_meta_t          meta_q [DEPTH];
  logic [DATA_W-1:0] res_q [DEPTH];

  ptr_t wp_q, wp_d, dp_q, dp_d, rp_q, rp_d, drop_q, drop_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;

  idx_t              wi_s, di_s, ri_s, hi_s;
  ptr_t              n_wait_s;
  logic              push_s, pop_s, rsp_drop_s, rsp_live_s, byp_s;
  logic              head_cap_s, head_done_s;
  logic [DATA_W-1:0] align_s;
  ld_meta_t          req_meta_s;

  assign wi_s     = wp_q[PW-1:0];
  assign di_s     = dp_q[PW-1:0];
  assign ri_s     = rp_q[PW-1:0];
  assign n_wait_s = wp_q - dp_q;
  assign count    = wp_q - rp_q;

  // Dropped responses still occupy capacity until they arrive.
  assign req_ready  = !flush && ((occ_t'(count) + occ_t'(drop_q)) < occ_t'(DEPTH));
  assign push_s     = req_valid && req_ready;
  assign rsp_drop_s = rsp_valid && (drop_q != '0);
  assign rsp_live_s = rsp_valid && (drop_q == '0) && (n_wait_s != '0);

  assign req_meta_s = '{size: req_size, sgn: req_signed,
                        off: OFF_MAX_W'(req_off), rd: RD_MAX_W'(req_rd)};

  load_align #(.DATA_W(DATA_W)) u_align (
    .data_i (rsp_data),
    .size_i (meta_q[di_s].size),
    .sign_i (meta_q[di_s].sgn),
    .off_i  (meta_q[di_s].off[OW-1:0]),
    .data_o (align_s)
  );

`ifdef WB_LOAD_BYPASS_EN
  assign byp_s = rsp_live_s && !flush && !wb_valid_q && (dp_q == rp_q);
`else
  assign byp_s = 1'b0;
`endif

  assign wb_valid = wb_valid_q | byp_s;
  assign wb_data  = byp_s ? align_s : wb_data_q;
  assign wb_rd    = byp_s ? meta_q[di_s].rd[RD_W-1:0] : wb_rd_q;
  assign pop_s    = wb_valid && wb_ready && !flush;

  // Entry state, pointer and drop-counter next state; flush overrides all
  always_comb begin
    st_d   = st_q;
    wp_d   = wp_q;
    dp_d   = dp_q;
    rp_d   = rp_q;
    drop_d = drop_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) st_d[i] = EMPTY;
      dp_d   = wp_q;
      rp_d   = wp_q;
      drop_d = drop_q + n_wait_s - ptr_t'(rsp_live_s) - ptr_t'(rsp_drop_s);
    end else begin
      if (rsp_drop_s) drop_d = drop_q - ptr_t'(1);
      else            drop_d = drop_q;
      if (rsp_live_s) begin
        st_d[di_s] = DONE;
        dp_d       = dp_q + ptr_t'(1);
      end else begin
        dp_d = dp_q;
      end
      if (pop_s) begin
        st_d[ri_s] = EMPTY;
        rp_d       = rp_q + ptr_t'(1);
      end else begin
        rp_d = rp_q;
      end
      if (push_s) begin
        st_d[wi_s] = WAIT;
        wp_d       = wp_q + ptr_t'(1);
      end else begin
        wp_d = wp_q;
      end
    end
  end

  // The head after this edge may complete this same cycle from the response.
  assign hi_s        = pop_s ? (ri_s + idx_t'(1)) : ri_s;
  assign head_cap_s  = rsp_live_s && (di_s == hi_s);
  assign head_done_s = head_cap_s || (st_q[hi_s] == DONE);

  // Writeback register reload from the (possibly new) head entry
  always_comb begin
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    if (flush) begin
      wb_valid_d = 1'b0;
    end else if (head_done_s) begin
      wb_valid_d = 1'b1;
      wb_data_d  = head_cap_s ? align_s : res_q[hi_s];
      wb_rd_d    = meta_q[hi_s].rd[RD_W-1:0];
    end else begin
      wb_valid_d = 1'b0;
    end
  end

  // Control state and writeback register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) st_q[i] <= EMPTY;
      wp_q       <= '0;
      dp_q       <= '0;
      rp_q       <= '0;
      drop_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
    end else begin
      st_q       <= st_d;
      wp_q       <= wp_d;
      dp_q       <= dp_d;
      rp_q       <= rp_d;
      drop_q     <= drop_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  // Entry payload: metadata at push, aligned result at capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        meta_q[i] <= '0;
        res_q[i]  <= '0;
      end
    end else begin
      if (push_s) meta_q[wi_s] <= req_meta_s;
      if (rsp_live_s && !flush) res_q[di_s] <= align_s;
    end
  end

`ifndef SYNTHESIS
  wb_load_queue_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .rsp_valid (rsp_valid),
    .drop_zero (drop_q == '0),
    .wait_none (n_wait_s == '0)
  );
`endif

endmodule
